slow_tick_bcd_counter: RTL

//   Consumes the divider's slowClk (~1.34 s period) in the clk100Mhz domain.

---
 rtl/slow_tick_bcd_counter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/slow_tick_bcd_counter.sv
// slow_tick_bcd_counter: synchronises the divider's slowClk into the
// clk100Mhz domain, turns each rising edge into a one-cycle tick and steps a
// DIGITS-digit BCD up/down counter. Supports parallel load with BCD
// validation, run/pause and single-step while paused.
module slow_tick_bcd_counter #(
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk100Mhz,
  input  logic                resetn,
  input  logic                slowClk,
  input  logic                run,
  input  logic                up,
  input  logic                step,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                tick,
  output logic                wrap,
  output logic                load_err,
  output logic                running
);

  localparam int unsigned W         = 4 * DIGITS;
  localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
  localparam int unsigned PW        = $clog2(PRIME_MAX + 1);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 edge_q;
  logic [PW-1:0]        prime_q;
  logic                 primed;
  logic                 rise;
  logic                 tick_int;
  logic                 adv;
  logic [W-1:0]         step_val;
  logic                 step_wrap;
  logic                 load_bad;

  // slowClk synchroniser chain (bit 0 samples the pin) plus previous-value register for edge detect
  always_ff @(posedge clk100Mhz) begin
    if (!resetn) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slowClk};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // prime counter: hold off ticks until the synchroniser has flushed post-reset data
  always_ff @(posedge clk100Mhz) begin
    if (!resetn) begin
      prime_q <= '0;
    end else if (!primed) begin
      prime_q <= prime_q + 1'b1;
    end
  end

  assign primed   = (prime_q == PW'(PRIME_MAX));
  assign rise     = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign tick_int = rise & primed;

  // run/pause state register
  always_ff @(posedge clk100Mhz) begin
    if (!resetn) begin
      state_q <= PAUSE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; adv is gated by the pre-edge state
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    case (state_q)
      PAUSE: begin
        adv = step;
        if (run) state_d = RUN;
      end
      RUN: begin
        adv = tick_int;
        if (!run) state_d = PAUSE;
      end
      default: state_d = PAUSE;
    endcase
  end

  assign running = (state_q == RUN);

  // ripple BCD increment/decrement of the current count; carry/borrow out flags a wrap
  always_comb begin
    logic [3:0] d;
    logic       c;
    step_val = bcd_out;
    c        = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = bcd_out[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d >= 4'd9) begin
            d = 4'd0;
            c = 1'b1;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = 4'd9;
            c = 1'b1;
          end else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      step_val[4*i +: 4] = d;
    end
    step_wrap = c;
  end

  // flag a load value containing any non-BCD digit
  always_comb begin
    load_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_bad = 1'b1;
    end
  end

  // count register and output pulses; load wins over adv and discards it
  always_ff @(posedge clk100Mhz) begin
    if (!resetn) begin
      bcd_out  <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= tick_int;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_bad) load_err <= 1'b1;
        else          bcd_out  <= load_val;
      end else if (adv) begin
        bcd_out <= step_val;
        wrap    <= step_wrap;
      end
    end
  end

endmodule
